mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
// The requester uses the master modport and the responder uses the slave modport.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_burst;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_burst,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_burst,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with registered single-beat responses.
// Define MEM_RESPONDER_BURST_EN to add 8-beat aligned burst reads.
module mem_responder #(
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 4
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t               state_r, nxt_state_s;
  logic [3:0]           cnt_r, nxt_cnt_s;
  logic [2:0]           beat_r, nxt_beat_s;
  logic                 wr_r;
  logic [DEPTH_W-1:0]   addr_r;
  logic [15:0]          wdata_r;
  logic                 burst_s;
  logic                 rsp_valid_r, nxt_valid_s;
  logic                 rsp_last_r, nxt_last_s;
  logic [15:0]          rsp_data_r, nxt_data_s;
  logic                 accept_s;
  logic                 launch_s;
  logic [DEPTH_W-1:0]   rd_idx_s;
  logic [15:0]          mem_r [0:(1<<DEPTH_W)-1];

  assign accept_s      = bus.req_valid && (state_r == IDLE);
  assign bus.req_ready = (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.rsp_data  = rsp_data_r;

`ifdef MEM_RESPONDER_BURST_EN
  logic burst_r;

  // Capture burst intent; a burst flag on a write is dropped at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_r <= 1'b0;
    end else if (accept_s) begin
      burst_r <= bus.req_burst && !bus.req_wr;
    end else begin
      burst_r <= burst_r;
    end
  end

  assign burst_s  = burst_r;
  assign rd_idx_s = burst_r ? {addr_r[DEPTH_W-1:3], beat_r} : addr_r;
`else
  assign burst_s  = 1'b0;
  assign rd_idx_s = addr_r;
`endif

  // Request capture; the upper address bits alias onto the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
    end else if (accept_s) begin
      wr_r    <= bus.req_wr;
      addr_r  <= bus.req_addr[DEPTH_W-1:0];
      wdata_r <= bus.req_wdata;
    end else begin
      wr_r    <= wr_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Next-state and next-output logic; XFER launches one beat per cycle until the last one is out.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_beat_s  = beat_r;
    nxt_valid_s = 1'b0;
    nxt_last_s  = 1'b0;
    nxt_data_s  = 16'h0000;
    launch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          nxt_beat_s = 3'd0;
          if (LATENCY == 1) begin
            nxt_state_s = XFER;
          end else begin
            nxt_state_s = WAIT;
            nxt_cnt_s   = WAIT_LOAD;
          end
        end else begin
          nxt_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          nxt_state_s = XFER;
        end else begin
          nxt_cnt_s = cnt_r - 4'd1;
        end
      end
      XFER: begin
        if (rsp_last_r) begin
          nxt_state_s = IDLE;
        end else begin
          launch_s    = 1'b1;
          nxt_valid_s = 1'b1;
          nxt_data_s  = wr_r ? 16'h0000 : mem_r[rd_idx_s];
          nxt_last_s  = burst_s ? (beat_r == 3'd7) : 1'b1;
          nxt_beat_s  = beat_r + 3'd1;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      beat_r      <= 3'd0;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= 16'h0000;
    end else begin
      state_r     <= nxt_state_s;
      cnt_r       <= nxt_cnt_s;
      beat_r      <= nxt_beat_s;
      rsp_valid_r <= nxt_valid_s;
      rsp_last_r  <= nxt_last_s;
      rsp_data_r  <= nxt_data_s;
    end
  end

  // Array write commits on the edge that launches the write response.
  always_ff @(posedge clk) begin
    if (launch_s && wr_r) begin
      mem_r[addr_r] <= wdata_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 instance for the main flow,
// LATENCY=1 instance for minimum latency and address aliasing.
module tb_mem_responder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  mem_responder #(.DEPTH_W(10), .LATENCY(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  mem_responder #(.DEPTH_W(10), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request on if0 and returns 1 ns after its accept edge.
  task automatic issue0(input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic burst);
    if0.req_valid = 1'b1;
    if0.req_wr    = wr;
    if0.req_addr  = addr;
    if0.req_wdata = wdata;
    if0.req_burst = burst;
    tick();
    if0.req_valid = 1'b0;
  endtask

  // Checks a single-beat response on if0, starting just after the accept edge.
  task automatic single0(input string tag, input logic [15:0] exp_data);
    chk({tag, "_busy"}, {15'd0, if0.busy}, 16'd1);
    tick(); tick(); tick();
    chk({tag, "_early"}, {15'd0, if0.rsp_valid}, 16'd0);
    tick();
    chk({tag, "_valid"}, {15'd0, if0.rsp_valid}, 16'd1);
    chk({tag, "_data"}, if0.rsp_data, exp_data);
    chk({tag, "_last"}, {15'd0, if0.rsp_last}, 16'd1);
    chk({tag, "_rdy_lo"}, {15'd0, if0.req_ready}, 16'd0);
    tick();
    chk({tag, "_done"}, {15'd0, if0.rsp_valid}, 16'd0);
    chk({tag, "_dzero"}, if0.rsp_data, 16'h0000);
    chk({tag, "_rdy_hi"}, {15'd0, if0.req_ready}, 16'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    if0.req_valid = 1'b0; if0.req_wr = 1'b0; if0.req_addr = 16'h0;
    if0.req_wdata = 16'h0; if0.req_burst = 1'b0;
    if1.req_valid = 1'b0; if1.req_wr = 1'b0; if1.req_addr = 16'h0;
    if1.req_wdata = 16'h0; if1.req_burst = 1'b0;
    #12;
    chk("rst_ready", {15'd0, if0.req_ready}, 16'd1);
    chk("rst_busy",  {15'd0, if0.busy},      16'd0);
    chk("rst_valid", {15'd0, if0.rsp_valid}, 16'd0);
    chk("rst_last",  {15'd0, if0.rsp_last},  16'd0);
    chk("rst_data",  if0.rsp_data,           16'h0000);

    // Write accepted on the first edge after reset release
    rst_n = 1'b1;
    issue0(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    single0("wr10", 16'h0000);
    issue0(1'b0, 16'h0010, 16'h0000, 1'b0);
    single0("rd10", 16'hBEEF);

    // Request held while busy: no extra accept, captured request unchanged
    issue0(1'b1, 16'h0041, 16'h5555, 1'b0);
    single0("wr41", 16'h0000);
    issue0(1'b1, 16'h0040, 16'h4444, 1'b0);
    if0.req_valid = 1'b1;
    if0.req_addr  = 16'h0041;
    if0.req_wdata = 16'hDEAD;
    tick(); tick(); tick();
    chk("hold_early", {15'd0, if0.rsp_valid}, 16'd0);
    tick();
    chk("hold_valid", {15'd0, if0.rsp_valid}, 16'd1);
    tick();
    chk("hold_ready", {15'd0, if0.req_ready}, 16'd1);
    if0.req_valid = 1'b0;
    tick();
    chk("hold_noacc", {15'd0, if0.busy}, 16'd0);
    issue0(1'b0, 16'h0040, 16'h0000, 1'b0);
    single0("rd40", 16'h4444);
    issue0(1'b0, 16'h0041, 16'h0000, 1'b0);
    single0("rd41", 16'h5555);

    // Reset during WAIT of a write discards it
    issue0(1'b1, 16'h0030, 16'h1111, 1'b0);
    single0("wr30", 16'h0000);
    issue0(1'b1, 16'h0030, 16'h2222, 1'b0);
    tick();
    chk("mid_busy", {15'd0, if0.busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {15'd0, if0.req_ready}, 16'd1);
    chk("mid_rst_busy",  {15'd0, if0.busy},      16'd0);
    chk("mid_rst_valid", {15'd0, if0.rsp_valid}, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_rsp", {15'd0, if0.rsp_valid}, 16'd0);
    end
    issue0(1'b0, 16'h0030, 16'h0000, 1'b0);
    single0("rd30", 16'h1111);

    // Fill 0x20..0x27 and read with the burst flag set
    for (int k = 0; k < 8; k++) begin
      issue0(1'b1, 16'h0020 + 16'(k), 16'h1000 + 16'(k), 1'b0);
      single0("fill", 16'h0000);
    end
    issue0(1'b0, 16'h0023, 16'h0000, 1'b1);
    tick(); tick(); tick();
    chk("bst_early", {15'd0, if0.rsp_valid}, 16'd0);
`ifdef MEM_RESPONDER_BURST_EN
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("bst_valid", {15'd0, if0.rsp_valid}, 16'd1);
      chk("bst_data", if0.rsp_data, 16'h1000 + 16'(k));
      chk("bst_last", {15'd0, if0.rsp_last}, (k == 7) ? 16'd1 : 16'd0);
    end
`else
    tick();
    chk("bst_valid", {15'd0, if0.rsp_valid}, 16'd1);
    chk("bst_data", if0.rsp_data, 16'h1003);
    chk("bst_last", {15'd0, if0.rsp_last}, 16'd1);
`endif
    tick();
    chk("bst_done",  {15'd0, if0.rsp_valid}, 16'd0);
    chk("bst_ready", {15'd0, if0.req_ready}, 16'd1);

    // LATENCY=1 instance: write 0x0010, then read through alias 0xFC10
    if1.req_valid = 1'b1; if1.req_wr = 1'b1;
    if1.req_addr = 16'h0010; if1.req_wdata = 16'hA5A5;
    tick();
    if1.req_valid = 1'b0;
    chk("l1_wr_busy", {15'd0, if1.busy}, 16'd1);
    tick();
    chk("l1_wr_valid", {15'd0, if1.rsp_valid}, 16'd1);
    chk("l1_wr_data",  if1.rsp_data,           16'h0000);
    tick();
    chk("l1_wr_ready", {15'd0, if1.req_ready}, 16'd1);
    if1.req_valid = 1'b1; if1.req_wr = 1'b0;
    if1.req_addr = 16'hFC10; if1.req_wdata = 16'h0000;
    tick();
    if1.req_valid = 1'b0;
    chk("l1_rd_pending", {15'd0, if1.rsp_valid}, 16'd0);
    tick();
    chk("l1_rd_valid", {15'd0, if1.rsp_valid}, 16'd1);
    chk("l1_rd_data",  if1.rsp_data,           16'hA5A5);
    chk("l1_rd_last",  {15'd0, if1.rsp_last},  16'd1);
    tick();
    chk("l1_rd_done",  {15'd0, if1.rsp_valid}, 16'd0);
    chk("l1_rd_ready", {15'd0, if1.req_ready}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
